sram_port_arbiter: RTL and testbench

//  Shares one native SRAM port (req/we/addr/wdata/wmask/wcap -> rdata/rcap/rvalid)

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_rr.sv | 57 +++++
 rtl/sram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
package sram_arb_pkg;

  // Width reserved for a requester index inside a tracker entry (up to 16 requesters).
  localparam int TrkIdxW = 4;

  // Index width needed to number n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One in-flight read: whether a read was issued and who issued it.
  typedef struct packed {
    logic               valid;
    logic [TrkIdxW-1:0] idx;
  } rd_track_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
// With SRAM_ARB_PRIO_EN defined, requester 0 always wins and the rotation
// covers requesters 1..NumReq-1 only.
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter int NumReq = 3,
  parameter int IdxW   = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr,
  output logic [IdxW-1:0]   winner,
  output logic [NumReq-1:0] gnt,
  output logic              any
);

  int j_s;

  // Search from the pointer, wrapping modulo NumReq, and keep the first hit.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    j_s    = 0;
`ifdef SRAM_ARB_PRIO_EN
    if (req[0]) begin
      any    = 1'b1;
      winner = '0;
    end else begin
      any    = 1'b0;
    end
`endif
    for (int k = 0; k < NumReq; k++) begin
      j_s = int'(rr) + k;
      if (j_s >= NumReq) begin
        j_s = j_s - NumReq;
      end else begin
        j_s = j_s;
      end
`ifdef SRAM_ARB_PRIO_EN
      if (!any && req[j_s] && (j_s != 0)) begin
`else
      if (!any && req[j_s]) begin
`endif
        any    = 1'b1;
        winner = IdxW'(j_s);
      end else begin
        any    = any;
      end
    end
    if (any) begin
      gnt = NumReq'(1) << winner;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one native SRAM port between NumReq requesters with round-robin grants
// and routes each read response back to the requester that issued it.
// Optional macro: SRAM_ARB_PRIO_EN gives requester 0 fixed priority.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NumReq      = 3,
  parameter int SramAw      = 15,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  output logic [NumReq-1:0]                   gnt_o,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][SramAw-1:0]       addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wmask_i,
  input  logic [NumReq-1:0]                   wcap_i,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                rcap_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [SramAw-1:0]                   mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [DataWidth-1:0]                mem_wmask_o,
  output logic                                mem_wcap_o,
  input  logic [DataWidth-1:0]                mem_rdata_i,
  input  logic                                mem_rcap_i,
  input  logic                                mem_rvalid_i,
  output logic                                err_o
);

  localparam int              IdxW    = idx_w(NumReq);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] winner_s;
  logic            any_s;
  rd_track_t       trk_q [ReadLatency];
  rd_track_t       tail_s;
  logic            err_q;

  sram_arb_rr #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr (
    .req    (req_i),
    .rr     (rr_q),
    .winner (winner_s),
    .gnt    (gnt_o),
    .any    (any_s)
  );

  assign tail_s = trk_q[ReadLatency-1];
  assign err_o  = err_q;

  // Steer the winner's fields onto the SRAM port; drive zeros when idle.
  always_comb begin
    if (any_s) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[winner_s];
      mem_addr_o  = addr_i[winner_s];
      mem_wdata_o = wdata_i[winner_s];
      mem_wmask_o = wmask_i[winner_s];
      mem_wcap_o  = wcap_i[winner_s];
    end else begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wmask_o = '0;
      mem_wcap_o  = 1'b0;
    end
  end

  // Route a response to the requester recorded at the tracker tail.
  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (tail_s.idx == TrkIdxW'(i)) begin
        rvalid_o[i] = mem_rvalid_i & tail_s.valid;
      end else begin
        rvalid_o[i] = 1'b0;
      end
    end
  end

  assign rdata_o = mem_rdata_i;
  assign rcap_o  = mem_rcap_i;

  // Advance the round-robin pointer past the requester just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
`ifdef SRAM_ARB_PRIO_EN
    end else if (any_s && (winner_s != '0)) begin
      rr_q <= (winner_s == LastIdx) ? IdxW'(1) : winner_s + IdxW'(1);
`else
    end else if (any_s) begin
      rr_q <= (winner_s == LastIdx) ? '0 : winner_s + IdxW'(1);
`endif
    end else begin
      rr_q <= rr_q;
    end
  end

  // Shift issued reads through the latency pipeline, one stage per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < ReadLatency; s++) begin
        trk_q[s] <= '0;
      end
    end else begin
      trk_q[0].valid <= mem_req_o & ~mem_we_o;
      trk_q[0].idx   <= TrkIdxW'(winner_s);
      for (int s = 1; s < ReadLatency; s++) begin
        trk_q[s] <= trk_q[s-1];
      end
    end
  end

  // Latch any disagreement between SRAM response and tracked reads until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (mem_rvalid_i != tail_s.valid) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at ReadLatency=1 and one
// at ReadLatency=3, each fed by a small SRAM response model.
module tb_sram_port_arbiter;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // shared request fields
  logic [2:0][14:0] addr;
  logic [2:0][31:0] wdata;
  logic [2:0][31:0] wmask;
  logic [2:0]       wcap;
  logic [31:0]      rd_data;
  logic             rd_cap;

  // latency-1 instance
  logic        rst_n;
  logic [2:0]  req, we, gnt, rvalid;
  logic [31:0] rdata, mem_wdata, mem_wmask;
  logic        rcap, mem_req, mem_we, mem_wcap, mem_rvalid, err;
  logic [14:0] mem_addr;
  logic        rv1, inject;

  // latency-3 instance
  logic        rst3_n;
  logic [2:0]  req3, we3, gnt3, rvalid3;
  logic [31:0] rdata3, mem_wdata3, mem_wmask3;
  logic        rcap3, mem_req3, mem_we3, mem_wcap3, mem_rvalid3, err3;
  logic [14:0] mem_addr3;
  logic [2:0]  rv3;

  sram_port_arbiter #(.NumReq(3), .SramAw(15), .DataWidth(32), .ReadLatency(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .wcap_i(wcap),
    .rvalid_o(rvalid), .rdata_o(rdata), .rcap_o(rcap),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_wcap_o(mem_wcap),
    .mem_rdata_i(rd_data), .mem_rcap_i(rd_cap), .mem_rvalid_i(mem_rvalid),
    .err_o(err)
  );

  sram_port_arbiter #(.NumReq(3), .SramAw(15), .DataWidth(32), .ReadLatency(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst3_n), .req_i(req3), .gnt_o(gnt3), .we_i(we3),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .wcap_i(wcap),
    .rvalid_o(rvalid3), .rdata_o(rdata3), .rcap_o(rcap3),
    .mem_req_o(mem_req3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
    .mem_wdata_o(mem_wdata3), .mem_wmask_o(mem_wmask3), .mem_wcap_o(mem_wcap3),
    .mem_rdata_i(rd_data), .mem_rcap_i(rd_cap), .mem_rvalid_i(mem_rvalid3),
    .err_o(err3)
  );

  // SRAM models: a read answers ReadLatency cycles after it is issued.
  always @(posedge clk_i) begin
    rv1 <= mem_req & ~mem_we;
    rv3 <= {rv3[1:0], mem_req3 & ~mem_we3};
  end
  assign mem_rvalid  = rv1 | inject;
  assign mem_rvalid3 = rv3[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  logic [2:0] exp_g  [5];
  logic [2:0] exp_rv [5];

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    req = 3'b000; we = 3'b000; req3 = 3'b000; we3 = 3'b000;
    inject = 1'b0; rv1 = 1'b0; rv3 = 3'b000;
    addr  = '0; wdata = '0; wmask = '0; wcap = 3'b000;
    rd_data = 32'h0000_0000; rd_cap = 1'b0;

    // 1. reset state
    next_cycle();
    @(negedge clk_i);
    check_eq("rst_gnt", 64'(gnt), 64'd0);
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    next_cycle();
    rst_n = 1'b1; rst3_n = 1'b1;

    addr[0] = 15'h0001; addr[1] = 15'h0002; addr[2] = 15'h0003;
`ifdef SRAM_ARB_PRIO_EN
    // 6. requester 0 dominates, then 1 and 2 alternate
    exp_g  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    exp_rv = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001};
    for (int i = 0; i < 5; i++) begin
      req = (i < 4) ? 3'b111 : 3'b000;
      @(negedge clk_i);
      check_eq($sformatf("prio_gnt%0d", i), 64'(gnt), 64'(exp_g[i]));
      check_eq($sformatf("prio_rv%0d", i), 64'(rvalid), 64'(exp_rv[i]));
      next_cycle();
    end
    exp_g  = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b000};
    exp_rv = '{3'b000, 3'b010, 3'b100, 3'b010, 3'b100};
    for (int i = 0; i < 5; i++) begin
      req = (i < 4) ? 3'b110 : 3'b000;
      @(negedge clk_i);
      check_eq($sformatf("prio_alt_gnt%0d", i), 64'(gnt), 64'(exp_g[i]));
      check_eq($sformatf("prio_alt_rv%0d", i), 64'(rvalid), 64'(exp_rv[i]));
      next_cycle();
    end
`else
    // 1. all three read: round-robin 0,1,2,0 with responses one cycle later
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    exp_rv = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 5; i++) begin
      req = (i < 4) ? 3'b111 : 3'b000;
      @(negedge clk_i);
      check_eq($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(exp_g[i]));
      check_eq($sformatf("rr_rv%0d", i), 64'(rvalid), 64'(exp_rv[i]));
      next_cycle();
    end
`endif
    check_eq("rr_err", 64'(err), 64'd0);

    // 2. write from requester 1
    req = 3'b010; we = 3'b010;
    addr[1] = 15'h0010; wdata[1] = 32'hDEAD_BEEF; wmask[1] = 32'hFFFF_0000; wcap[1] = 1'b1;
    @(negedge clk_i);
    check_eq("wr_gnt", 64'(gnt), 64'h2);
    check_eq("wr_mem_req", 64'(mem_req), 64'd1);
    check_eq("wr_mem_we", 64'(mem_we), 64'd1);
    check_eq("wr_mem_addr", 64'(mem_addr), 64'h10);
    check_eq("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check_eq("wr_mem_wmask", 64'(mem_wmask), 64'hFFFF_0000);
    check_eq("wr_mem_wcap", 64'(mem_wcap), 64'd1);
    next_cycle();
    req = 3'b000; we = 3'b000; wcap = 3'b000;
    @(negedge clk_i);
    check_eq("wr_no_rvalid", 64'(rvalid), 64'd0);
    check_eq("idle_mem_req", 64'(mem_req), 64'd0);
    check_eq("idle_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("idle_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("idle_gnt", 64'(gnt), 64'd0);
    next_cycle();

    // 3. read from requester 2 with tagged data
    req = 3'b100; addr[2] = 15'h0020;
    rd_data = 32'hA5A5_A5A5; rd_cap = 1'b1;
    @(negedge clk_i);
    check_eq("rd2_gnt", 64'(gnt), 64'h4);
    check_eq("rd2_mem_we", 64'(mem_we), 64'd0);
    check_eq("rd2_mem_addr", 64'(mem_addr), 64'h20);
    next_cycle();
    req = 3'b000;
    @(negedge clk_i);
    check_eq("rd2_rvalid", 64'(rvalid), 64'h4);
    check_eq("rd2_rdata", 64'(rdata), 64'hA5A5_A5A5);
    check_eq("rd2_rcap", 64'(rcap), 64'd1);
    check_eq("rd2_err", 64'(err), 64'd0);
    next_cycle();

    // pointer now at 0: requester 0 absent, so 1 wins; then pointer 2 wraps to 0
    req = 3'b110;
    @(negedge clk_i);
    check_eq("skip_gnt", 64'(gnt), 64'h2);
    next_cycle();
    req = 3'b011;
    @(negedge clk_i);
    check_eq("wrap_gnt", 64'(gnt), 64'h1);
    check_eq("wrap_rv", 64'(rvalid), 64'h2);
    next_cycle();
    req = 3'b000;
    @(negedge clk_i);
    check_eq("wrap_rv_last", 64'(rvalid), 64'h1);
    next_cycle();
    next_cycle();

    // 4. unsolicited response sets sticky error
    inject = 1'b1;
    @(negedge clk_i);
    check_eq("inj_rvalid", 64'(rvalid), 64'd0);
    check_eq("inj_err_before", 64'(err), 64'd0);
    next_cycle();
    inject = 1'b0;
    @(negedge clk_i);
    check_eq("inj_err_set", 64'(err), 64'd1);
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check_eq("inj_err_held", 64'(err), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("inj_err_reset", 64'(err), 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // 5a. latency 3: reads by 0,1,2 answered on cycles 3,4,5
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    for (int c = 0; c < 7; c++) begin
      req3 = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : (c == 2) ? 3'b100 : 3'b000;
      @(negedge clk_i);
      if (c < 3) check_eq($sformatf("l3_gnt%0d", c), 64'(gnt3), 64'(exp_g[c]));
      check_eq($sformatf("l3_rv%0d", c), 64'(rvalid3),
               (c == 3) ? 64'h1 : (c == 4) ? 64'h2 : (c == 5) ? 64'h4 : 64'h0);
      next_cycle();
    end
    check_eq("l3_err", 64'(err3), 64'd0);

    // 5b. same reads, reset asserted at cycle 2 drops everything in flight
    for (int c = 0; c < 9; c++) begin
      req3 = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b000;
      if (c == 2) rst3_n = 1'b0;
      if (c == 5) rst3_n = 1'b1;
      @(negedge clk_i);
      check_eq($sformatf("l3rst_rv%0d", c), 64'(rvalid3), 64'd0);
      next_cycle();
    end
    check_eq("l3rst_err", 64'(err3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
